// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Brief   : Frame geometry and master FSM state encoding for spi_frame_master.
// Rev     : 1.0
// ============================================================================
package spi_pkg;

  localparam int FRAME_BITS = 40;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    XFER  = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } spi_mstate_t;

endpackage
`default_nettype wire

// File: rtl/sck_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : sck_tick_gen
// Brief   : Half-period tick enable; preloads while disabled so the first
//           tick lands HALF_DIV cycles after enable rises.
// Rev     : 1.0
// ============================================================================
module sck_tick_gen #(
  parameter int HALF_DIV = 25
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int                 c_cnt_w  = $clog2(HALF_DIV + 1);
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(HALF_DIV - 1);

  logic [c_cnt_w-1:0] r_count;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_count <= '0;
    end else if (!enable || (r_count == '0)) begin
      r_count <= c_reload;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tick = enable && (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/spi_frame_master.sv
`default_nettype none
// ============================================================================
// Module  : spi_frame_master
// Brief   : 40-bit SPI mode-0 frame master ({addr, data}, MSB first).
// Rev     : 1.0
// ============================================================================
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int HALF_DIV = 25
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] tx_addr,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] rx_addr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 spi_sck,
  output logic                 spi_cs_n,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  localparam logic [5:0] c_last_bit = 6'(FRAME_BITS - 1);

  spi_mstate_t           r_state, w_state_next;
  logic                  w_tick, w_rise, w_fall;
  logic                  r_phase;
  logic [5:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift, r_rx_shift;
  logic                  r_miso_s1, r_miso_s2, r_rise_d1, r_rise_d2;
  logic                  r_busy, r_done, r_sck, r_cs_n;
  logic [ADDR_BITS-1:0]  r_rx_addr;
  logic [DATA_BITS-1:0]  r_rx_data;

  sck_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (r_state != IDLE),
    .tick     (w_tick)
  );

  assign w_rise = (r_state == XFER) && w_tick && !r_phase;
  assign w_fall = (r_state == XFER) && w_tick && r_phase;

  // The done cycle is an IDLE cycle; r_done blocks a start landing on it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start && !r_done) w_state_next = LEAD;
      LEAD:    if (w_tick) w_state_next = XFER;
      XFER:    if (w_fall && (r_bit_cnt == c_last_bit)) w_state_next = TRAIL;
      TRAIL:   if (w_tick) w_state_next = GAP;
      GAP:     if (w_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sck      <= 1'b0;
      r_cs_n     <= 1'b1;
      r_phase    <= 1'b0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rx_shift <= '0;
      r_miso_s1  <= 1'b0;
      r_miso_s2  <= 1'b0;
      r_rise_d1  <= 1'b0;
      r_rise_d2  <= 1'b0;
      r_rx_addr  <= '0;
      r_rx_data  <= '0;
    end else begin
      r_busy    <= (w_state_next != IDLE);
      r_cs_n    <= (w_state_next == IDLE) || (w_state_next == GAP);
      r_done    <= (r_state == GAP) && w_tick;
      r_miso_s1 <= spi_miso;
      r_miso_s2 <= r_miso_s1;
      r_rise_d1 <= w_rise;
      r_rise_d2 <= r_rise_d1;
      if ((r_state == IDLE) && (w_state_next == LEAD)) begin
        r_shift   <= {tx_addr, tx_data};
        r_bit_cnt <= '0;
        r_phase   <= 1'b0;
      end
      if (w_rise) begin
        r_sck   <= 1'b1;
        r_phase <= 1'b1;
      end
      if (w_fall) begin
        r_sck   <= 1'b0;
        r_phase <= 1'b0;
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        if (r_bit_cnt != c_last_bit) r_bit_cnt <= r_bit_cnt + 6'd1;
      end
      // Pin value captured at the SCK rise reaches r_miso_s2 two cycles later.
      if (r_rise_d2) r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], r_miso_s2};
      if ((r_state == GAP) && w_tick) begin
        r_rx_addr <= r_rx_shift[FRAME_BITS-1:DATA_BITS];
        r_rx_data <= r_rx_shift[DATA_BITS-1:0];
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rx_addr  = r_rx_addr;
  assign rx_data  = r_rx_data;
  assign spi_sck  = r_sck;
  assign spi_cs_n = r_cs_n;
  assign spi_mosi = r_shift[FRAME_BITS-1];

endmodule
`default_nettype wire
